// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: N-coin vending credit controller with paced change and a double-dabble BCD credit view.
// Define VEND_CHANGE_EN to pay the post-vend remainder out as change instead of keeping it as credit.
module vend_credit_ctrl #(
  parameter int NUM_COINS = 3,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = {8'd10, 8'd5, 8'd1},
  parameter int PRICE = 15,
  parameter int MAX_CREDIT = 99,
  parameter int CHANGE_GAP = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_COINS-1:0]  coin_tick,
  input  logic                  cancel_tick,
  output logic                  vend,
  output logic                  change_tick,
  output logic                  coin_reject,
  output logic                  busy,
  output logic [CREDIT_W-1:0]   credit,
  output logic [4*DIGITS-1:0]   credit_bcd,
  output logic                  bcd_valid
);
  localparam int GW = CHANGE_GAP > 1 ? $clog2(CHANGE_GAP) : 1;
  localparam int CW = $clog2(CREDIT_W + 1);
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRC = CREDIT_W'(PRICE);
  localparam logic [GW-1:0] GAP_END = GW'(CHANGE_GAP - 1);
`ifdef VEND_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  state_t state;
  logic [GW-1:0] gap;
  logic [CREDIT_W-1:0] coin_val, remain;
  logic [CREDIT_W:0] sum;
  logic accept, extra;
  logic [CREDIT_W-1:0] snap, sh;
  logic [4*DIGITS-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic conv;
  // Lowest set coin bit wins; any other set bit only earns a reject.
  always_comb begin
    coin_val = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--)
      if (coin_tick[i]) coin_val = COIN_VALUES[i*CREDIT_W +: CREDIT_W];
    extra = |(coin_tick & (coin_tick - NUM_COINS'(1)));
    sum = {1'b0, credit} + {1'b0, coin_val};
    accept = |coin_tick && sum <= MAXC;
    remain = credit - PRC;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gap <= '0;
      credit <= '0;
      vend <= 1'b0;
      change_tick <= 1'b0;
      coin_reject <= 1'b0;
      busy <= 1'b0;
    end else begin
      vend <= 1'b0;
      change_tick <= 1'b0;
      coin_reject <= |coin_tick;
      case (state)
        IDLE: begin
          coin_reject <= |coin_tick && (!accept || extra);
          if (accept) begin
            credit <= sum[CREDIT_W-1:0];
            if (sum >= {1'b0, PRC}) begin
              state <= VEND;
              vend <= 1'b1;
              busy <= 1'b1;
            end
          end else if (cancel_tick && credit != '0) begin
            state <= CHANGE;
            gap <= '0;
            busy <= 1'b1;
          end
        end
        VEND: begin
          credit <= remain;
          if (CHG_EN && remain != '0) begin
            state <= CHANGE;
            gap <= '0;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        CHANGE: begin
          if (gap == GAP_END) begin
            gap <= '0;
            change_tick <= 1'b1;
            credit <= credit - CREDIT_W'(1);
            if (credit == CREDIT_W'(1)) begin
              state <= IDLE;
              busy <= 1'b0;
            end
          end else gap <= gap + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++)
      adj[4*d +: 4] = acc[4*d +: 4] >= 4'd5 ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
  end
  // snap is the value under conversion; any mismatch with credit restarts the shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      conv <= 1'b0;
      credit_bcd <= '0;
      bcd_valid <= 1'b1;
    end else if (credit != snap) begin
      snap <= credit;
      sh <= credit;
      acc <= '0;
      cnt <= CW'(CREDIT_W);
      conv <= 1'b1;
      bcd_valid <= 1'b0;
    end else if (conv) begin
      if (cnt != '0) begin
        {acc, sh} <= {adj, sh} << 1;
        cnt <= cnt - CW'(1);
      end else begin
        credit_bcd <= acc;
        bcd_valid <= 1'b1;
        conv <= 1'b0;
      end
    end
  end
endmodule
